logic_proc_control: RTL
=======================

// Module: logic_proc_control
// PURPOSE
//  Control unit for the bit-serial logic processor (A/B shift registers + compute/route unit).
//  Turns the LoadA/LoadB/Execute push buttons into register-load strobes and an exact run of
//  WIDTH shift-enable cycles per Execute press. Latches the function (F) and route (R) selects
//  for the run, so switch changes mid-operation cannot corrupt the result.
//  Sits between the input synchronizers and the register/compute datapath inside Processor.
// PARAMETERS
//  WIDTH   4   register width = number of shift cycles per execute (>=2)
// PORTS
//  Clk       in   1        system clock, all state on rising edge
//  Reset     in   1        asynchronous, active-high; forces IDLE and clears all outputs
//  LoadA     in   1        push button, active-low, pre-synchronized; load Din into A
//  LoadB     in   1        push button, active-low, pre-synchronized; load Din into B
//  Execute   in   1        push button, active-low, pre-synchronized; start one compute run
//  F         in   3        function select switches (sampled at run start only)
//  R         in   2        route select switches (sampled at run start only)
//  Ld_A      out  1        load strobe to register A (active-high)
//  Ld_B      out  1        load strobe to register B (active-high)
//  Shift_En  out  1        shift enable to A, B and compute unit (active-high)
//  F_q       out  3        latched function select to compute unit
//  R_q       out  2        latched route select to routing unit
//  Busy      out  1        high in any state except IDLE
//  Done      out  1        one-cycle pulse: final shift completed
// BEHAVIOUR
//  Reset: state=IDLE, count=0, F_q=0, R_q=0, Done=0; Ld_A/Ld_B/Shift_En/Busy are 0 as decoded from IDLE.
//  Reset mid-run aborts immediately; partial shifts are not undone.
//  States: IDLE, SHIFT, HOLD. Counter width $clog2(WIDTH).
//  IDLE:
//   - Ld_A = ~LoadA, Ld_B = ~LoadB (combinational from state and inputs; both may assert together).
//   - Execute==0 -> SHIFT next edge; same edge: count<=WIDTH-1, F_q<=F, R_q<=R.
//   - Execute==0 has priority: Ld_A/Ld_B are forced 0 in that cycle, even with LoadA/LoadB low.
//  SHIFT:
//   - Shift_En=1 and Busy=1 in every SHIFT cycle.
//   - count>0 -> count<=count-1; count==0 -> HOLD next edge and Done<=1.
//   - Shift_En is therefore high exactly WIDTH consecutive cycles, starting 1 cycle after Execute is seen low.
//  HOLD:
//   - Shift_En=0, Busy=1; Done is high in the first HOLD cycle only.
//   - Execute==1 (released) -> IDLE next edge; otherwise stay.
//   - One press = exactly one run; holding Execute never re-triggers.
//  Load inputs are ignored in SHIFT and HOLD (Ld_A=Ld_B=0).
//  F/R changes during SHIFT/HOLD: no effect on F_q/R_q until next run start.
//  Execute released during SHIFT: run still completes all WIDTH shifts; HOLD then exits on its first edge.
//  Done and F_q/R_q are registered; Ld_A, Ld_B, Shift_En and Busy are decoded from state (plus buttons for loads).
// TESTING
//  1. Reset=1 mid-SHIFT (count=2) -> same cycle Busy=0, Shift_En=0, F_q=0; after release, IDLE with LoadA=0 -> Ld_A=1.
//  2. IDLE, LoadA=0 2 cycles, then LoadB=0 2 cycles -> Ld_A high 2 cycles, then Ld_B high 2 cycles; Shift_En stays 0.
//  3. F=010, R=10, Execute=0 for 11 cycles -> Shift_En high cycles 1..4 exactly, Done=1 in cycle 5, F_q=010, R_q=10,
//     Busy high until 1 cycle after release.
//  4. Run started with F=010,R=10; switch to F=110,R=01 in 2nd shift cycle -> F_q/R_q hold 010/10; next press latches 110/01.
//  5. Execute=0 and LoadA=0 in same IDLE cycle -> Ld_A=0, run starts; LoadA held low through run -> no Ld_A until IDLE.
//  6. Execute pulsed low 1 cycle -> still 4 Shift_En cycles, Done pulse, then IDLE; WIDTH=8 variant -> 8 shifts.

Source files
------------

// File: rtl/logic_proc_control.sv
// logic_proc_control: button-to-strobe control for the bit-serial logic processor
module logic_proc_control #(
    parameter int WIDTH = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       LoadA,
    input  logic       LoadB,
    input  logic       Execute,
    input  logic [2:0] F,
    input  logic [1:0] R,
    output logic       Ld_A,
    output logic       Ld_B,
    output logic       Shift_En,
    output logic [2:0] F_q,
    output logic [1:0] R_q,
    output logic       Busy,
    output logic       Done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t state;
    logic [CW-1:0] count;
    logic idle;
    assign idle     = state == IDLE;
    // a pending Execute wins over the load buttons in the same cycle
    assign Ld_A     = idle & ~LoadA & Execute;
    assign Ld_B     = idle & ~LoadB & Execute;
    assign Shift_En = state == SHIFT;
    assign Busy     = ~idle;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            F_q   <= '0;
            R_q   <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: if (!Execute) begin
                    state <= SHIFT;
                    count <= CW'(WIDTH - 1);
                    F_q   <= F;
                    R_q   <= R;
                end
                SHIFT: if (count == '0) begin
                    state <= HOLD;
                    Done  <= 1'b1;
                end else count <= count - CW'(1);
                HOLD: if (Execute) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
